siggen_param_ctrl: RTL and testbench
====================================

Name: siggen_param_ctrl

Overview:
- Key-driven parameter controller for the signal generator.
- Turns debounced single-cycle key pulses into edits of waveform, frequency index and amplitude, held in shadow registers.
- Commits the shadow values to the DDS datapath only at a phase-accumulator wrap, so no glitched half-period is produced.
- Sits between the key_filter instances and the DDS/waveform-ROM/amplitude-scaler datapath.

Parameters:
WAVE_NUM, 4, number of waveforms; wave_sel ranges 0..WAVE_NUM-1 (0 sine, 1 square, 2 triangle, 3 sawtooth)
FREQ_MAX, 15, largest frequency index; freq_idx ranges 0..FREQ_MAX
AMP_MIN, 1, smallest amplitude code
AMP_MAX, 9, largest amplitude code
COMMIT_TO, 1000000, cycles to wait for phase_wrap before forcing a commit
IDLE_TO, 250000000, cycles with no key pulse before edit_field returns to WAVE

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
key_sel_flag  input  1  one-cycle pulse: advance edit field
key_up_flag  input  1  one-cycle pulse: increment the selected field
key_dn_flag  input  1  one-cycle pulse: decrement the selected field
phase_wrap  input  1  one-cycle pulse from the DDS when its phase accumulator wraps
edit_field  output  2  field being edited: 0 WAVE, 1 FREQ, 2 AMP
wave_sel  output  2  active waveform select
freq_idx  output  4  active frequency index
amplitude  output  5  active amplitude code
cfg_update  output  1  one-cycle pulse, high in the cycle the active outputs change
pending  output  1  shadow differs from active, commit outstanding

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - edit_field=0, wave_sel=0, freq_idx=0, amplitude=AMP_MIN.
  - Shadows equal the active values.
  - cfg_update=0, pending=0; both counters cleared; FSM=IDLE.
- Key priority per cycle is sel > up > dn.
  - up and dn together without sel: no change.
  - sel together with up or dn: only sel acts.
- key_sel_flag: edit_field steps 0→1→2→0. No data change, pending unaffected.
- Up/dn edits the shadow of the selected field in the same cycle.
  - Bounds: wave 0..WAVE_NUM-1, freq 0..FREQ_MAX, amp AMP_MIN..AMP_MAX.
  - At a bound, behaviour depends on the Optional Feature.
  - Any shadow change sets pending on the next edge.
  - An edit that leaves the value unchanged (saturation) does not set pending.
- FSM states:
  - IDLE → PENDING on a shadow change.
  - PENDING → COMMIT on phase_wrap, or when the commit counter reaches COMMIT_TO-1.
  - COMMIT lasts 1 cycle: active ← shadow, cfg_update=1, commit counter cleared, then → IDLE.
  - COMMIT → PENDING instead, if a shadow edit occurred during the COMMIT cycle or the cycle that triggered it.
- Commit latency: active outputs change on the 2nd edge after the phase_wrap cycle (one registered stage, then the COMMIT state).
- Capture rule: COMMIT copies shadow values as registered at the COMMIT cycle's entry. An edit in the same cycle lands next edge and re-arms pending.
- pending equals (FSM != IDLE) and deasserts together with the final cfg_update.
- phase_wrap in IDLE is ignored.
- Commit counter runs only in PENDING.
- Idle counter:
  - Cleared by any key pulse.
  - At IDLE_TO-1, edit_field ← 0. Saturates there, no further action.
- Reset mid-PENDING discards the shadow edits; there is no commit and no cfg_update.

Optional Feature:
- Macro SIGGEN_PARAM_WRAP_EN.
- Defined: up at max wraps to min, dn at min wraps to max. Wrapping counts as a change and sets pending.
- Undefined: values saturate at the bounds, and a saturated edit is a no-op.

Decomposition:
- Shared package siggen_pkg holds:
  - field encodings FIELD_WAVE/FIELD_FREQ/FIELD_AMP;
  - FSM state encodings;
  - waveform code constants;
  - the amplitude-range defaults.
- One natural sub-module: siggen_bound_step. Combinational step of value ±1 within [min,max], with wrap/saturate selected by the macro, and a changed flag. Instantiated once per field.

Test Plan:
- Reset, then hold idle 100 cycles → wave_sel=0, freq_idx=0, amplitude=1, pending=0, cfg_update never high.
- sel×2 (AMP), up×3, no phase_wrap → amplitude stays 1 and pending=1. Then phase_wrap → amplitude=4 two edges later with a single cfg_update pulse, pending=0.
- AMP field, up×12 without macro → commit gives amplitude=9. With SIGGEN_PARAM_WRAP_EN, 9 up-pulses from 1 wrap to 1 → commit gives amplitude=1.
- FREQ field, up once, phase_wrap held low → forced commit after COMMIT_TO cycles (set to 16 in the bench): freq_idx=1, cfg_update=1.
- key_up_flag in the same cycle as the phase_wrap that triggers a commit → first commit carries the old shadow. pending re-asserts and the next phase_wrap commits the new value.
- key_sel and key_up in the same cycle → edit_field advances and no value changes. Separately, rst pulsed while pending=1 → all outputs return to reset values with no cfg_update.

Source files
------------

// File: rtl/siggen_pkg.sv
// ============================================================================
// Module      : siggen_pkg
// Description : Shared encodings for the signal-generator parameter control:
//               edit-field codes, controller state codes, waveform codes,
//               amplitude-range defaults and the parameter-set record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package siggen_pkg;

   // Field currently targeted by the up/down keys
   localparam logic [1:0] FIELD_WAVE = 2'd0;
   localparam logic [1:0] FIELD_FREQ = 2'd1;
   localparam logic [1:0] FIELD_AMP  = 2'd2;

   // Waveform select codes understood by the waveform ROM
   localparam logic [1:0] WAVE_SINE     = 2'd0;
   localparam logic [1:0] WAVE_SQUARE   = 2'd1;
   localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
   localparam logic [1:0] WAVE_SAW      = 2'd3;

   // Default amplitude code range
   localparam int AMP_MIN_DEF = 1;
   localparam int AMP_MAX_DEF = 9;

   // Commit controller states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   // One complete parameter set (shadow, snapshot or active copy)
   typedef struct packed {
      logic [1:0] wave;
      logic [3:0] freq;
      logic [4:0] amp;
   } cfg_t;

   // Edit field rotates WAVE -> FREQ -> AMP -> WAVE
   function automatic logic [1:0] next_field(input logic [1:0] f);
      return (f == FIELD_AMP) ? FIELD_WAVE : f + 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/siggen_bound_step.sv
// ============================================================================
// Module      : siggen_bound_step
// Description : Combinational +/-1 step of a value inside [MIN_VAL,MAX_VAL].
//               At a bound the value wraps to the opposite bound when
//               SIGGEN_PARAM_WRAP_EN is defined, otherwise it saturates.
//               'changed' flags that the result differs from the input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module siggen_bound_step #(
   parameter int WIDTH   = 4,
   parameter int MIN_VAL = 0,
   parameter int MAX_VAL = 15
) (
   input  logic [WIDTH-1:0] value,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] next_value,
   output logic             changed
);

   localparam logic [WIDTH-1:0] C_MIN = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);

   // Bounded step; increment wins if a caller ever asserts both
   always_comb begin
      next_value = value;
      if (inc) begin
         if (value >= C_MAX) begin
`ifdef SIGGEN_PARAM_WRAP_EN
            next_value = C_MIN;
`else
            next_value = C_MAX;
`endif
         end else begin
            next_value = value + WIDTH'(1);
         end
      end else if (dec) begin
         if (value <= C_MIN) begin
`ifdef SIGGEN_PARAM_WRAP_EN
            next_value = C_MAX;
`else
            next_value = C_MIN;
`endif
         end else begin
            next_value = value - WIDTH'(1);
         end
      end
      changed = (next_value != value);
   end

endmodule

`default_nettype wire

// File: rtl/siggen_param_ctrl.sv
// ============================================================================
// Module      : siggen_param_ctrl
// Description : Key-driven parameter controller. Key pulses edit shadow
//               copies of waveform, frequency index and amplitude; the
//               shadow set is committed to the DDS datapath only at a phase
//               accumulator wrap (or after a forced-commit timeout).
//               Optional macro SIGGEN_PARAM_WRAP_EN: edits wrap at the
//               bounds instead of saturating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module siggen_param_ctrl
   import siggen_pkg::*;
#(
   parameter int WAVE_NUM  = 4,
   parameter int FREQ_MAX  = 15,
   parameter int AMP_MIN   = AMP_MIN_DEF,
   parameter int AMP_MAX   = AMP_MAX_DEF,
   parameter int COMMIT_TO = 1000000,
   parameter int IDLE_TO   = 250000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_sel_flag,
   input  logic       key_up_flag,
   input  logic       key_dn_flag,
   input  logic       phase_wrap,
   output logic [1:0] edit_field,
   output logic [1:0] wave_sel,
   output logic [3:0] freq_idx,
   output logic [4:0] amplitude,
   output logic       cfg_update,
   output logic       pending
);

   localparam int CW = (COMMIT_TO > 1) ? $clog2(COMMIT_TO) : 1;
   localparam int IW = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;
   localparam logic [CW-1:0] C_COMMIT_LAST = CW'(COMMIT_TO - 1);
   localparam logic [IW-1:0] C_IDLE_LAST   = IW'(IDLE_TO - 1);
   localparam cfg_t C_CFG_RESET = '{wave: WAVE_SINE, freq: 4'd0, amp: 5'(AMP_MIN)};

   state_t        state_q, state_d;
   cfg_t          shadow_q, shadow_d;
   cfg_t          snap_q, snap_d;
   cfg_t          active_q, active_d;
   logic [1:0]    edit_field_q, edit_field_d;
   logic [CW-1:0] commit_cnt_q, commit_cnt_d;
   logic [IW-1:0] idle_cnt_q, idle_cnt_d;
   logic          rearm_q, rearm_d;
   logic          cfg_update_q, cfg_update_d;

   // Resolved key actions: sel dominates, simultaneous up+dn cancels
   logic w_up, w_dn, w_any_key;
   assign w_up      = ~key_sel_flag & key_up_flag & ~key_dn_flag;
   assign w_dn      = ~key_sel_flag & key_dn_flag & ~key_up_flag;
   assign w_any_key = key_sel_flag | key_up_flag | key_dn_flag;

   logic [1:0] w_wave_next;
   logic [3:0] w_freq_next;
   logic [4:0] w_amp_next;
   logic       w_wave_chg, w_freq_chg, w_amp_chg, w_change;

   siggen_bound_step #(.WIDTH(2), .MIN_VAL(0), .MAX_VAL(WAVE_NUM - 1)) u_step_wave (
      .value      (shadow_q.wave),
      .inc        (w_up && (edit_field_q == FIELD_WAVE)),
      .dec        (w_dn && (edit_field_q == FIELD_WAVE)),
      .next_value (w_wave_next),
      .changed    (w_wave_chg)
   );

   siggen_bound_step #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(FREQ_MAX)) u_step_freq (
      .value      (shadow_q.freq),
      .inc        (w_up && (edit_field_q == FIELD_FREQ)),
      .dec        (w_dn && (edit_field_q == FIELD_FREQ)),
      .next_value (w_freq_next),
      .changed    (w_freq_chg)
   );

   siggen_bound_step #(.WIDTH(5), .MIN_VAL(AMP_MIN), .MAX_VAL(AMP_MAX)) u_step_amp (
      .value      (shadow_q.amp),
      .inc        (w_up && (edit_field_q == FIELD_AMP)),
      .dec        (w_dn && (edit_field_q == FIELD_AMP)),
      .next_value (w_amp_next),
      .changed    (w_amp_chg)
   );

   assign w_change = w_wave_chg | w_freq_chg | w_amp_chg;

   // Shadow edits, edit-field rotation and idle return to the WAVE field
   always_comb begin
      shadow_d     = '{wave: w_wave_next, freq: w_freq_next, amp: w_amp_next};
      edit_field_d = edit_field_q;
      idle_cnt_d   = idle_cnt_q;
      if (w_any_key) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q != C_IDLE_LAST) begin
         idle_cnt_d = idle_cnt_q + IW'(1);
         // One-shot: fires only on the cycle the counter reaches its limit
         if (idle_cnt_d == C_IDLE_LAST) begin
            edit_field_d = FIELD_WAVE;
         end
      end
      if (key_sel_flag) begin
         edit_field_d = next_field(edit_field_q);
      end
   end

   // Commit sequencing; the snapshot freezes the shadow that existed before
   // the trigger edge so edits racing the trigger go to the next commit
   always_comb begin
      state_d      = state_q;
      snap_d       = snap_q;
      active_d     = active_q;
      rearm_d      = rearm_q;
      commit_cnt_d = '0;
      cfg_update_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_change) begin
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (phase_wrap || (commit_cnt_q == C_COMMIT_LAST)) begin
               state_d = ST_COMMIT;
               snap_d  = shadow_q;
               rearm_d = w_change;
            end else begin
               commit_cnt_d = commit_cnt_q + CW'(1);
            end
         end
         ST_COMMIT: begin
            active_d     = snap_q;
            cfg_update_d = 1'b1;
            state_d      = (rearm_q || w_change) ? ST_PENDING : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shadow_q     <= C_CFG_RESET;
         snap_q       <= C_CFG_RESET;
         active_q     <= C_CFG_RESET;
         edit_field_q <= FIELD_WAVE;
         commit_cnt_q <= '0;
         idle_cnt_q   <= '0;
         rearm_q      <= 1'b0;
         cfg_update_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         snap_q       <= snap_d;
         active_q     <= active_d;
         edit_field_q <= edit_field_d;
         commit_cnt_q <= commit_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
         rearm_q      <= rearm_d;
         cfg_update_q <= cfg_update_d;
      end
   end

   assign edit_field = edit_field_q;
   assign wave_sel   = active_q.wave;
   assign freq_idx   = active_q.freq;
   assign amplitude  = active_q.amp;
   assign cfg_update = cfg_update_q;
   assign pending    = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_siggen_param_ctrl.sv
// ============================================================================
// Module      : tb_siggen_param_ctrl
// Description : Scoreboard bench for siggen_param_ctrl. A reference model
//               tracks the user-visible parameter state; each predicted
//               commit is queued and popped by a monitor on cfg_update.
//               Honours SIGGEN_PARAM_WRAP_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_siggen_param_ctrl;

   localparam int WAVE_NUM  = 4;
   localparam int FREQ_MAX  = 15;
   localparam int AMP_MIN   = 1;
   localparam int AMP_MAX   = 9;
   localparam int COMMIT_TO = 16;
   localparam int IDLE_TO   = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ks = 1'b0, ku = 1'b0, kd = 1'b0, pw = 1'b0;
   logic [1:0] ef, ws;
   logic [3:0] fi;
   logic [4:0] amp;
   logic       cu, pend;

   siggen_param_ctrl #(
      .WAVE_NUM (WAVE_NUM), .FREQ_MAX (FREQ_MAX), .AMP_MIN (AMP_MIN),
      .AMP_MAX  (AMP_MAX),  .COMMIT_TO(COMMIT_TO), .IDLE_TO (IDLE_TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .key_sel_flag (ks),
      .key_up_flag  (ku),
      .key_dn_flag  (kd),
      .phase_wrap   (pw),
      .edit_field   (ef),
      .wave_sel     (ws),
      .freq_idx     (fi),
      .amplitude    (amp),
      .cfg_update   (cu),
      .pending      (pend)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct { int w; int f; int a; } cfg_s;
   cfg_s exp_q[$];

   // Reference model: values as plain integers indexed by field
   int lo[3] = '{0, 0, AMP_MIN};
   int hi[3] = '{WAVE_NUM - 1, FREQ_MAX, AMP_MAX};
   int m_field;
   int m_sh[3];
   int m_act[3];
   int m_snap[3];
   bit m_pend;      // a commit is outstanding (waiting or in progress)
   bit m_commit;    // next edge copies the snapshot to the outputs
   bit m_rearm;
   int m_wait;      // cycles spent waiting for a wrap
   int m_quiet;     // cycles since the last key pulse
   bit m_cfg;       // outputs changed at the last edge

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_field = 0;
      m_sh    = '{0, 0, AMP_MIN};
      m_act   = '{0, 0, AMP_MIN};
      m_snap  = '{0, 0, AMP_MIN};
      m_pend = 0; m_commit = 0; m_rearm = 0;
      m_wait = 0; m_quiet = 0; m_cfg = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input bit s, input bit u, input bit d, input bit w);
      int  old_sh[3];
      bit  edited;
      int  v;
      old_sh = m_sh;
      edited = 0;
      m_cfg  = 0;
      if (s || u || d) m_quiet = 0;
      else if (m_quiet != IDLE_TO - 1) begin
         m_quiet++;
         if (m_quiet == IDLE_TO - 1) m_field = 0;
      end
      if (s) m_field = (m_field + 1) % 3;
      else if (u != d) begin
         v = m_sh[m_field] + (u ? 1 : -1);
`ifdef SIGGEN_PARAM_WRAP_EN
         if (v > hi[m_field]) v = lo[m_field];
         if (v < lo[m_field]) v = hi[m_field];
`else
         if (v > hi[m_field]) v = hi[m_field];
         if (v < lo[m_field]) v = lo[m_field];
`endif
         edited = (v != m_sh[m_field]);
         m_sh[m_field] = v;
      end
      if (m_commit) begin
         m_act    = m_snap;
         m_cfg    = 1;
         exp_q.push_back('{w: m_snap[0], f: m_snap[1], a: m_snap[2]});
         m_commit = 0;
         m_pend   = m_rearm || edited;
         m_wait   = 0;
      end else if (m_pend) begin
         if (w || m_wait == COMMIT_TO - 1) begin
            m_commit = 1;
            m_snap   = old_sh;
            m_rearm  = edited;
            m_wait   = 0;
         end else m_wait++;
      end else if (edited) begin
         m_pend = 1;
         m_wait = 0;
      end
   endtask

   task automatic check_all();
      check("edit_field", int'(ef),   m_field);
      check("wave_sel",   int'(ws),   m_act[0]);
      check("freq_idx",   int'(fi),   m_act[1]);
      check("amplitude",  int'(amp),  m_act[2]);
      check("pending",    int'(pend), int'(m_pend));
      check("cfg_update", int'(cu),   int'(m_cfg));
   endtask

   task automatic tick(input bit s, input bit u, input bit d, input bit w);
      ks = s; ku = u; kd = d; pw = w;
      model_step(s, u, d, w);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      ks = 0; ku = 0; kd = 0; pw = 0;
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all();
   endtask

   // Monitor: every cfg_update pulse must match the oldest predicted commit
   cfg_s mon_e;
   always @(negedge clk) begin
      if (!rst && cu === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL commit_unexpected: got cfg_update=1 expected none at %0t", $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("commit_wave", int'(ws),  mon_e.w);
            check("commit_freq", int'(fi),  mon_e.f);
            check("commit_amp",  int'(amp), mon_e.a);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_up;
      int amp_exp;

      // Reset and quiet hold
      do_reset();
      idle(100);
      check("idle_wave", int'(ws), 0);
      check("idle_freq", int'(fi), 0);
      check("idle_amp",  int'(amp), 1);
      check("idle_pend", int'(pend), 0);

      // Idle timeout returns the edit field to WAVE
      tick(1, 0, 0, 0);
      check("sel_field", int'(ef), 1);
      idle(60);
      check("idle_to_field", int'(ef), 0);

      // Amplitude +3 committed on a phase wrap
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      check("amp_field", int'(ef), 2);
      for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
      idle(5);
      check("amp_held", int'(amp), 1);
      check("amp_pend", int'(pend), 1);
      tick(0, 0, 0, 1);
      check("amp_stage1", int'(amp), 1);
      tick(0, 0, 0, 0);
      check("amp_commit", int'(amp), 4);
      check("amp_cfg", int'(cu), 1);
      check("amp_pend_clr", int'(pend), 0);
      idle(3);

      // Amplitude upper bound: saturate or wrap
      do_reset();
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
`ifdef SIGGEN_PARAM_WRAP_EN
      n_up = 9; amp_exp = 1;
`else
      n_up = 12; amp_exp = 9;
`endif
      for (int i = 0; i < n_up; i++) tick(0, 1, 0, 0);
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 0);
      check("amp_bound", int'(amp), amp_exp);
      idle(3);

      // Forced commit with no phase wrap
      do_reset();
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      idle(COMMIT_TO);
      check("force_before", int'(fi), 0);
      check("force_pend", int'(pend), 1);
      tick(0, 0, 0, 0);
      check("force_freq", int'(fi), 1);
      check("force_cfg", int'(cu), 1);
      idle(3);

      // Edit racing the triggering wrap goes to the following commit
      do_reset();
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
      tick(0, 1, 0, 1);
      tick(0, 0, 0, 0);
      check("race_first", int'(amp), 2);
      check("race_cfg", int'(cu), 1);
      check("race_rearm", int'(pend), 1);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 0);
      check("race_second", int'(amp), 3);
      check("race_done", int'(pend), 0);

      // sel with up: only the field moves
      do_reset();
      tick(1, 1, 0, 0);
      check("selup_field", int'(ef), 1);
      check("selup_pend", int'(pend), 0);
      tick(0, 1, 1, 0);
      check("updn_pend", int'(pend), 0);

      // Reset while a commit is outstanding
      tick(0, 1, 0, 0);
      check("rst_pre_pend", int'(pend), 1);
      do_reset();
      check("rst_freq", int'(fi), 0);
      check("rst_pend", int'(pend), 0);
      idle(COMMIT_TO + 4);
      check("rst_no_commit", int'(fi), 0);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom % 10) == 0, ($urandom % 5) == 0,
              ($urandom % 5) == 0, ($urandom % 12) == 0);
      end
      idle(2 * COMMIT_TO + 8);
      check("queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
